// File: rtl/sram_like_arbiter.sv
// sram_like_arbiter: merges the instruction and data SRAM-like master ports
// into one SRAM-like port toward the memory side. Requests are arbitrated one
// at a time. An in-order owner FIFO steers each response back to the port that
// issued the request. At most OUTSTANDING requests may be accepted but not yet
// answered.
// Optional feature: define SRAM_ARB_ROUND_ROBIN_EN to make simultaneous
// requests alternate between the ports. When it is undefined, data always
// wins over inst.
module sram_like_arbiter #(
    parameter int OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic        inst_req,
    input  logic [1:0]  inst_size,
    input  logic [31:0] inst_addr,
    output logic [31:0] inst_rdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic [31:0] data_rdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,

    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok
);

    localparam int CW = $clog2(OUTSTANDING + 1);
    localparam int PW = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
    localparam logic [CW-1:0] COUNT_MAX = CW'(OUTSTANDING);
    localparam logic [PW-1:0] PTR_LAST  = PW'(OUTSTANDING - 1);

    // Owner encoding: 0 = inst, 1 = data.
    logic [OUTSTANDING-1:0] owner_fifo;
    logic [PW-1:0]          wr_ptr;
    logic [PW-1:0]          rd_ptr;
    logic [CW-1:0]          count;
    logic                   lock_valid;
    logic                   lock_owner;

    logic full;
    logic both_pick;
    logic grant_owner;
    logic grant_req;
    logic accept;
    logic pop;
    logic head_owner;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    // Acceptance is blocked while full, even if a pop happens in the same
    // cycle. This keeps the full check independent of mem_data_ok.
    assign full = (count == COUNT_MAX);

`ifdef SRAM_ARB_ROUND_ROBIN_EN
    logic rr_last;

    // Remember which port won the most recent accept; a tie goes to the other one.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            rr_last <= 1'b0;
        else if (accept)
            rr_last <= grant_owner;
    end

    assign both_pick = ~rr_last;
`else
    assign both_pick = 1'b1;
`endif

    // Pick the owner of the memory port: a held lock first, then the tie rule.
    always_comb begin
        grant_owner = 1'b0;
        if (lock_valid)
            grant_owner = lock_owner;
        else if (inst_req && data_req)
            grant_owner = both_pick;
        else
            grant_owner = data_req;
    end

    assign grant_req = grant_owner ? data_req : inst_req;

    assign mem_req   = resetn & ~full & grant_req;
    assign mem_wr    = resetn & grant_owner & data_wr;
    assign mem_size  = resetn ? (grant_owner ? data_size : inst_size) : 2'b00;
    assign mem_addr  = resetn ? (grant_owner ? data_addr : inst_addr) : 32'h0;
    assign mem_wdata = (resetn && grant_owner) ? data_wdata : 32'h0;

    assign accept       = mem_req & mem_addr_ok;
    assign inst_addr_ok = accept & ~grant_owner;
    assign data_addr_ok = accept & grant_owner;

    // A response that arrives while nothing is outstanding is dropped.
    assign head_owner   = owner_fifo[rd_ptr];
    assign pop          = resetn & mem_data_ok & (count != '0);
    assign inst_data_ok = pop & ~head_owner;
    assign data_data_ok = pop & head_owner;

    assign inst_rdata = resetn ? mem_rdata : 32'h0;
    assign data_rdata = resetn ? mem_rdata : 32'h0;

    // Owner FIFO: push on accept, pop on a counted response.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            owner_fifo <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
        end else begin
            if (accept) begin
                owner_fifo[wr_ptr] <= grant_owner;
                wr_ptr             <= ptr_next(wr_ptr);
            end
            if (pop)
                rd_ptr <= ptr_next(rd_ptr);
            if (accept && !pop)
                count <= count + 1'b1;
            else if (pop && !accept)
                count <= count - 1'b1;
        end
    end

    // Hold the grant on a pending request so mem_addr stays stable until it is accepted.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lock_valid <= 1'b0;
            lock_owner <= 1'b0;
        end else begin
            lock_valid <= mem_req & ~mem_addr_ok;
            lock_owner <= grant_owner;
        end
    end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Testbench for sram_like_arbiter: directed scenarios plus a randomized run
// checked against a queue-based reference model. It follows SRAM_ARB_ROUND_ROBIN_EN
// in the same way as the design.
module tb_sram_like_arbiter;

    localparam int NOUT = 2;

    logic        clk;
    logic        resetn;
    logic        inst_req;
    logic [1:0]  inst_size;
    logic [31:0] inst_addr;
    logic [31:0] inst_rdata;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [31:0] data_rdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic        mem_req;
    logic        mem_wr;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_addr_ok;
    logic        mem_data_ok;

    // Handshake outputs in one vector: {mem_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}
    logic [4:0]  hs;
    assign hs = {mem_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok};

    int errors = 0;
    int checks = 0;

    sram_like_arbiter #(.OUTSTANDING(NOUT)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .inst_req     (inst_req),
        .inst_size    (inst_size),
        .inst_addr    (inst_addr),
        .inst_rdata   (inst_rdata),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_rdata   (data_rdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .mem_req      (mem_req),
        .mem_wr       (mem_wr),
        .mem_size     (mem_size),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_addr_ok  (mem_addr_ok),
        .mem_data_ok  (mem_data_ok)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got time limit reached, expected end of test sequence");
        $fatal(1, "watchdog expired");
    end

    // Stimulus per cycle {inst_req, data_req, mem_addr_ok, mem_data_ok} and the expected handshake.
    // An address entry of 0 means mem_addr is not checked in that cycle.
`ifdef SRAM_ARB_ROUND_ROBIN_EN
    localparam int ARB_N = 9;
    localparam logic [3:0]  ARB_STIM [ARB_N] = '{4'b1110, 4'b1110, 4'b1110, 4'b1111, 4'b1110,
                                                 4'b1111, 4'b1110, 4'b0011, 4'b0011};
    localparam logic [4:0]  ARB_HS   [ARB_N] = '{5'b10100, 5'b11000, 5'b00000, 5'b00001, 5'b10100,
                                                 5'b00010, 5'b11000, 5'b00001, 5'b00010};
    localparam logic [31:0] ARB_ADDR [ARB_N] = '{32'h8000_0100, 32'hBFC0_0000, 32'h0, 32'h0,
                                                 32'h8000_0100, 32'h0, 32'hBFC0_0000, 32'h0, 32'h0};
`else
    localparam int ARB_N = 7;
    localparam logic [3:0]  ARB_STIM [ARB_N] = '{4'b1110, 4'b1110, 4'b1110, 4'b1011, 4'b1010,
                                                 4'b0011, 4'b0011};
    localparam logic [4:0]  ARB_HS   [ARB_N] = '{5'b10100, 5'b10100, 5'b00000, 5'b00001, 5'b11000,
                                                 5'b00001, 5'b00010};
    localparam logic [31:0] ARB_ADDR [ARB_N] = '{32'h8000_0100, 32'h8000_0100, 32'h0, 32'h0,
                                                 32'hBFC0_0000, 32'h0, 32'h0};
`endif

    task automatic idle_inputs;
        inst_req    = 1'b0;
        inst_size   = 2'd0;
        inst_addr   = 32'h0;
        data_req    = 1'b0;
        data_wr     = 1'b0;
        data_size   = 2'd0;
        data_addr   = 32'h0;
        data_wdata  = 32'h0;
        mem_rdata   = 32'h0;
        mem_addr_ok = 1'b0;
        mem_data_ok = 1'b0;
    endtask

    task automatic test_reset;
        resetn      = 1'b0;
        inst_req    = 1'b1;
        inst_size   = 2'd2;
        inst_addr   = 32'hBFC0_0000;
        data_req    = 1'b1;
        data_wr     = 1'b1;
        data_size   = 2'd2;
        data_addr   = 32'h8000_0100;
        data_wdata  = 32'hFFFF_FFFF;
        mem_rdata   = 32'h1234_5678;
        mem_addr_ok = 1'b1;
        mem_data_ok = 1'b1;
        #1;
        checks++;
        if (hs !== 5'b00000) begin
            errors++;
            $display("FAIL reset_handshake: got %b expected 00000", hs);
        end
        checks++;
        if ({mem_wr, mem_size, mem_addr, mem_wdata} !== 67'd0) begin
            errors++;
            $display("FAIL reset_payload: got wr=%b size=%0d addr=%h wdata=%h expected all 0",
                     mem_wr, mem_size, mem_addr, mem_wdata);
        end
        checks++;
        if ({inst_rdata, data_rdata} !== 64'd0) begin
            errors++;
            $display("FAIL reset_rdata: got %h/%h expected 0/0", inst_rdata, data_rdata);
        end
        @(negedge clk);
        idle_inputs();
        resetn = 1'b1;
    endtask

    task automatic test_arbitration;
        inst_addr  = 32'hBFC0_0000;
        inst_size  = 2'd2;
        data_addr  = 32'h8000_0100;
        data_size  = 2'd2;
        data_wr    = 1'b1;
        data_wdata = 32'h55AA_55AA;
        for (int i = 0; i < ARB_N; i++) begin
            {inst_req, data_req, mem_addr_ok, mem_data_ok} = ARB_STIM[i];
            #1;
            checks++;
            if (hs !== ARB_HS[i]) begin
                errors++;
                $display("FAIL arb_handshake[%0d]: got %b expected %b", i, hs, ARB_HS[i]);
            end
            if (ARB_ADDR[i] != 32'h0) begin
                checks++;
                if (mem_addr !== ARB_ADDR[i]) begin
                    errors++;
                    $display("FAIL arb_addr[%0d]: got %h expected %h", i, mem_addr, ARB_ADDR[i]);
                end
            end
            if (ARB_HS[i][3]) begin
                checks++;
                if ({mem_wr, mem_wdata} !== 33'd0) begin
                    errors++;
                    $display("FAIL arb_inst_payload[%0d]: got wr=%b wdata=%h expected 0/0",
                             i, mem_wr, mem_wdata);
                end
            end
            @(negedge clk);
        end
        idle_inputs();
        @(negedge clk);
    endtask

    task automatic test_grant_lock;
        logic [4:0] exp_hs [5] = '{5'b10000, 5'b10000, 5'b10000, 5'b11000, 5'b10100};
        inst_addr = 32'hBFC0_0000;
        data_addr = 32'h8000_0300;
        data_wr   = 1'b1;
        for (int i = 0; i < 5; i++) begin
            inst_req    = (i < 4);
            data_req    = (i >= 1);
            mem_addr_ok = (i >= 3);
            #1;
            checks++;
            if (hs !== exp_hs[i]) begin
                errors++;
                $display("FAIL lock_handshake[%0d]: got %b expected %b", i, hs, exp_hs[i]);
            end
            checks++;
            if (mem_addr !== ((i < 4) ? 32'hBFC0_0000 : 32'h8000_0300)) begin
                errors++;
                $display("FAIL lock_addr[%0d]: got %h expected %h", i, mem_addr,
                         (i < 4) ? 32'hBFC0_0000 : 32'h8000_0300);
            end
            @(negedge clk);
        end
        idle_inputs();
        mem_data_ok = 1'b1;
        #1;
        checks++;
        if (hs !== 5'b00010) begin
            errors++;
            $display("FAIL lock_resp_inst: got %b expected 00010", hs);
        end
        @(negedge clk);
        #1;
        checks++;
        if (hs !== 5'b00001) begin
            errors++;
            $display("FAIL lock_resp_data: got %b expected 00001", hs);
        end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_response_routing;
        inst_req    = 1'b1;
        inst_addr   = 32'hBFC0_0004;
        mem_addr_ok = 1'b1;
        #1;
        checks++;
        if (hs !== 5'b11000) begin
            errors++;
            $display("FAIL route_accept_inst: got %b expected 11000", hs);
        end
        @(negedge clk);
        inst_req   = 1'b0;
        data_req   = 1'b1;
        data_wr    = 1'b1;
        data_size  = 2'd2;
        data_addr  = 32'h8000_0200;
        data_wdata = 32'hDEAD_BEEF;
        #1;
        checks++;
        if ({hs, mem_wr, mem_size, mem_wdata} !== {5'b10100, 1'b1, 2'd2, 32'hDEAD_BEEF}) begin
            errors++;
            $display("FAIL route_accept_data: got hs=%b wr=%b size=%0d wdata=%h expected 10100/1/2/deadbeef",
                     hs, mem_wr, mem_size, mem_wdata);
        end
        @(negedge clk);
        data_req    = 1'b0;
        mem_addr_ok = 1'b0;
        mem_data_ok = 1'b1;
        mem_rdata   = 32'h2402_0001;
        #1;
        checks++;
        if ({hs, inst_rdata} !== {5'b00010, 32'h2402_0001}) begin
            errors++;
            $display("FAIL route_resp_inst: got hs=%b rdata=%h expected 00010/24020001", hs, inst_rdata);
        end
        @(negedge clk);
        mem_rdata = 32'h1111_2222;
        #1;
        checks++;
        if ({hs, data_rdata} !== {5'b00001, 32'h1111_2222}) begin
            errors++;
            $display("FAIL route_resp_data: got hs=%b rdata=%h expected 00001/11112222", hs, data_rdata);
        end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_full_simultaneous_pop;
        logic [4:0] exp_hs [7] = '{5'b10100, 5'b10100, 5'b00001, 5'b10100, 5'b00000, 5'b00001, 5'b00001};
        data_addr   = 32'h8000_0400;
        mem_addr_ok = 1'b1;
        for (int i = 0; i < 7; i++) begin
            data_req    = (i < 5);
            mem_data_ok = (i == 2) || (i >= 5);
            #1;
            checks++;
            if (hs !== exp_hs[i]) begin
                errors++;
                $display("FAIL full_pop[%0d]: got %b expected %b", i, hs, exp_hs[i]);
            end
            @(negedge clk);
        end
        idle_inputs();
    endtask

    task automatic test_reset_spurious;
        logic [4:0] exp_hs [6] = '{5'b00000, 5'b10100, 5'b10100, 5'b00000, 5'b00001, 5'b00001};
        inst_req    = 1'b1;
        inst_addr   = 32'hBFC0_0008;
        mem_addr_ok = 1'b1;
        #1;
        checks++;
        if (hs !== 5'b11000) begin
            errors++;
            $display("FAIL rst_pre_accept: got %b expected 11000", hs);
        end
        @(negedge clk);
        data_req    = 1'b1;
        data_addr   = 32'h8000_0500;
        mem_data_ok = 1'b1;
        mem_rdata   = 32'hCAFE_0000;
        #1;
        resetn = 1'b0;
        #1;
        checks++;
        if ({hs, mem_addr, inst_rdata, data_rdata} !== {5'b00000, 96'd0}) begin
            errors++;
            $display("FAIL rst_async: got hs=%b addr=%h rdata=%h/%h expected all 0",
                     hs, mem_addr, inst_rdata, data_rdata);
        end
        @(negedge clk);
        idle_inputs();
        resetn = 1'b1;
        data_addr = 32'h8000_0500;
        for (int i = 0; i < 6; i++) begin
            data_req    = (i >= 1) && (i <= 3);
            mem_addr_ok = (i >= 1) && (i <= 3);
            mem_data_ok = (i == 0) || (i >= 4);
            #1;
            checks++;
            if (hs !== exp_hs[i]) begin
                errors++;
                $display("FAIL rst_spurious[%0d]: got %b expected %b", i, hs, exp_hs[i]);
            end
            @(negedge clk);
        end
        idle_inputs();
    endtask

    task automatic test_random;
        int   q[$];
        bit   pend_v;
        bit   pend_o;
        bit   rr;
        bit   ih;
        bit   dh;
        bit   owner;
        bit   rq;
        bit   acc;
        bit   popv;
        bit   head;
        logic [4:0]  exp_hs;
        logic [66:0] exp_pay;
        idle_inputs();
        resetn = 1'b0;
        #1;
        @(negedge clk);
        resetn = 1'b1;
        pend_v = 1'b0;
        pend_o = 1'b0;
        rr     = 1'b0;
        ih     = 1'b0;
        dh     = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (!ih) begin
                inst_req  = ($urandom_range(0, 2) != 0);
                inst_addr = $urandom;
                inst_size = 2'($urandom_range(0, 2));
            end
            if (!dh) begin
                data_req   = ($urandom_range(0, 2) != 0);
                data_wr    = 1'($urandom_range(0, 1));
                data_size  = 2'($urandom_range(0, 2));
                data_addr  = $urandom;
                data_wdata = $urandom;
            end
            mem_addr_ok = ($urandom_range(0, 3) != 0);
            mem_data_ok = ($urandom_range(0, 2) == 0);
            mem_rdata   = $urandom;

            owner = 1'b0;
            rq    = 1'b0;
            if (q.size() < NOUT) begin
                if (pend_v) begin
                    owner = pend_o;
                    rq    = owner ? data_req : inst_req;
                end else if (inst_req && data_req) begin
`ifdef SRAM_ARB_ROUND_ROBIN_EN
                    owner = !rr;
`else
                    owner = 1'b1;
`endif
                    rq = 1'b1;
                end else begin
                    owner = data_req;
                    rq    = inst_req || data_req;
                end
            end
            acc    = rq && mem_addr_ok;
            popv   = mem_data_ok && (q.size() > 0);
            head   = (q.size() > 0) ? (q[0] != 0) : 1'b0;
            exp_hs = {rq, acc && !owner, acc && owner, popv && !head, popv && head};
            exp_pay = owner ? {data_wr, data_size, data_addr, data_wdata}
                            : {1'b0, inst_size, inst_addr, 32'h0};
            #1;
            checks++;
            if (hs !== exp_hs) begin
                errors++;
                $display("FAIL rand_handshake[%0d]: got %b expected %b", cyc, hs, exp_hs);
            end
            if (rq) begin
                checks++;
                if ({mem_wr, mem_size, mem_addr, mem_wdata} !== exp_pay) begin
                    errors++;
                    $display("FAIL rand_payload[%0d]: got %h expected %h", cyc,
                             {mem_wr, mem_size, mem_addr, mem_wdata}, exp_pay);
                end
            end
            checks++;
            if ({inst_rdata, data_rdata} !== {mem_rdata, mem_rdata}) begin
                errors++;
                $display("FAIL rand_rdata[%0d]: got %h/%h expected %h", cyc, inst_rdata, data_rdata, mem_rdata);
            end

            if (popv)
                void'(q.pop_front());
            if (acc) begin
                q.push_back(int'(owner));
                rr = owner;
            end
            pend_v = rq && !acc;
            pend_o = owner;
            ih = inst_req && !(acc && !owner);
            dh = data_req && !(acc && owner);
            @(negedge clk);
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        resetn = 1'b0;
        test_reset();
        test_arbitration();
        test_grant_lock();
        test_response_routing();
        test_full_simultaneous_pop();
        test_reset_spurious();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sram_like_arbiter.md
# sram_like_arbiter

Merges the core's instruction and data SRAM-like master ports into one SRAM-like master port toward the memory side (cache or AXI bridge). Sits directly downstream of the pipeline top's `inst_*` / `data_*` handshake outputs. Arbitration is per request. An in-order owner FIFO routes each returning `mem_data_ok` / `mem_rdata` back to the port that issued it. Up to `OUTSTANDING` accepted-but-unanswered transactions are allowed.

## Interface
- `OUTSTANDING`, default 2: maximum accepted-but-unanswered downstream transactions; legal range 1..8.
- `clk` in 1: sole clock, rising edge.
- `resetn` in 1: reset, asynchronous, active-low.
- `inst_req` in 1: instruction request; always a read.
- `inst_size` in 2: transfer size.
- `inst_addr` in 32: instruction address.
- `inst_rdata` out 32: read data, routed from `mem_rdata`.
- `inst_addr_ok` out 1: instruction request accepted this cycle.
- `inst_data_ok` out 1: instruction response this cycle.
- `data_req` in 1: data request.
- `data_wr` in 1: 1 = write.
- `data_size` in 2: 0 = byte, 1 = half, 2 = word.
- `data_addr` in 32: data address.
- `data_wdata` in 32: write data.
- `data_rdata` out 32: read data, routed from `mem_rdata`.
- `data_addr_ok` out 1: data request accepted this cycle.
- `data_data_ok` out 1: data response this cycle.
- `mem_req`, `mem_wr`, `mem_size` (2), `mem_addr` (32), `mem_wdata` (32): out; merged request.
- `mem_rdata` in 32, `mem_addr_ok` in 1, `mem_data_ok` in 1: memory-side handshake.

## Operation
- **Owner FIFO**
  - `OUTSTANDING` entries of 1 bit each: 0 = inst, 1 = data.
  - Read/write pointers plus a `count` register of width clog2(`OUTSTANDING`+1).
- **Full rule**
  - `full = (count == OUTSTANDING)`.
  - While full, `mem_req` = 0 and both `*_addr_ok` = 0.
  - A pop in the same cycle does not lift the block; acceptance resumes the next cycle.
- **Grant**
  - Only `inst_req` high: grant inst. Only `data_req` high: grant data. Neither high: `mem_req` = 0.
  - Both high: without the macro, data wins; with the macro, see Configuration.
  - `mem_wr`/`mem_size`/`mem_addr`/`mem_wdata` mux from the granted port.
  - When inst is granted, `mem_wr` = 0 and `mem_wdata` = 0.
- **Grant lock**
  - Applies when `mem_req` = 1 and `mem_addr_ok` = 0.
  - Register `lock_valid` / `lock_owner` holds the grant until `mem_addr_ok`, even if the other port raises `req`.
  - This keeps `mem_addr` stable while a request is pending.
- **Accept**
  - `mem_req & mem_addr_ok` pushes the owner bit and pulses the owner's `*_addr_ok` in the same cycle (combinational).
  - The non-owner's `addr_ok` stays 0.
  - Accepting clears the lock.
- **Response**
  - On `mem_data_ok` with `count > 0`: pop the head and assert the head owner's `*_data_ok` in the same cycle (combinational).
  - `inst_rdata` and `data_rdata` both equal `mem_rdata` at all times.
- **Spurious response**: `mem_data_ok` with `count == 0` is ignored. No pulse, no pointer change.
- **Simultaneous push and pop** (not full): `count` is unchanged and both pointers advance.
- **Pointer wrap-around**: pointers wrap modulo `OUTSTANDING`.

## Timing
- **Reset**
  - `count`, pointers, `lock_valid` and `rr_last` (round-robin state) clear to 0 asynchronously.
  - While `resetn` = 0, all outputs are 0, including `mem_req`, both `addr_ok`, both `data_ok` and the `mem_*` payload.
- **Latency**
  - Zero added cycles on the request path.
  - Zero added cycles on the response path.
  - Combinational paths: `*_req` → `mem_req`, and `mem_addr_ok` → `*_addr_ok`.
- **Reset mid-operation**: the FIFO is emptied. Responses arriving after release with `count == 0` are dropped under the spurious rule.
- **Acceptance throughput**: one per cycle while not full.

## Configuration
- `SRAM_ARB_ROUND_ROBIN_EN` defined:
  - When both ports request with no lock held, grant the port not granted on the last accept (`rr_last`).
  - `rr_last` updates on every accept.
- Macro undefined:
  - Fixed priority, data over inst.
  - `rr_last` is not instantiated.

## Test plan
- **Both ports request, `OUTSTANDING` = 2, `mem_addr_ok` = 1 every cycle, macro off:**
  - Data (addr 0x8000_0100) accepted in cycle 0 and cycle 1.
  - Inst is accepted only when `data_req` drops.
  - `count` reaches 2 and then blocks further acceptance.
- **Same stimulus, macro on:**
  - Grants alternate data, inst, data, inst.
  - `inst_addr_ok` pulses on accepts 2 and 4.
- **Grant lock:**
  - Inst requests 0xBFC0_0000 with `mem_addr_ok` held 0 for 3 cycles.
  - `data_req` rises in cycle 1.
  - `mem_addr` stays 0xBFC0_0000 until accept; data is granted the next cycle.
- **Response routing:**
  - Accept inst, then data (write 0xDEAD_BEEF, size 2).
  - First `mem_data_ok` with `mem_rdata` = 0x2402_0001 → `inst_data_ok` = 1 only.
  - Second `mem_data_ok` → `data_data_ok` = 1 only.
- **Full with simultaneous pop:**
  - `count` = 2, `mem_data_ok` = 1 and a pending `req` in the same cycle.
  - No accept that cycle; accept the next cycle; `count` ends at 2.
- **Reset and spurious response:**
  - Deassert `resetn` asynchronously with `count` = 1; all outputs go 0 immediately.
  - After release, one `mem_data_ok` produces no `data_ok` pulse and `count` stays 0.
